rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one ALU datapath slot among up to eight requesters. It selects a requester, holds the grant until release, abandonment or timeout, and advances a rotating priority pointer so every requester is served fairly. Grant is delivered both as a 3-bit index (A/B/C select of the 3-to-8 decoder path) and as a one-hot vector. It sits between the requester-side control logic and the shared ALU operand/result muxes.

---
 rtl/rr_arbiter8_if.sv | 20 ++
 rtl/rr_arbiter8.sv | 80 ++++++++
 tb/tb_rr_arbiter8.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requester-side control logic and the
// round-robin arbiter that owns the shared ALU datapath slot.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt_valid, gnt_idx, gnt, timeout
    );

    modport slave (
        input  req, done,
        output gnt_valid, gnt_idx, gnt, timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: one grant at a time, held until DONE,
// abandonment or MAX_HOLD timeout, with a rotating priority pointer.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rr_arbiter8_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hcnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic [7:0] r_gnt;
    logic       r_timeout;

    logic       w_any;
    logic [2:0] w_pick;
    logic       w_release;
    logic       w_expire;

    // Lowest offset from the pointer wins, so scan downwards and let later hits overwrite.
    always_comb begin
        w_any  = |bus.req;
        w_pick = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[r_ptr + 3'(k)]) w_pick = r_ptr + 3'(k);
        end
    end

    // A normal release (DONE or abandon) outranks a simultaneous timeout.
    assign w_release = bus.done || !bus.req[r_gnt_idx];
    assign w_expire  = (MAX_HOLD != 0) && (r_hcnt == HOLD_LAST) && !w_release;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_hcnt      <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 8'h00;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_pick;
                        r_gnt_valid <= 1'b1;
                        r_gnt       <= 8'h01 << w_pick;
                        r_hcnt      <= 8'd0;
                    end
                end
                GRANT: begin
                    if (r_hcnt != 8'hFF) r_hcnt <= r_hcnt + 8'd1;
                    if (w_release || w_expire) begin
                        r_state     <= IDLE;
                        r_ptr       <= r_gnt_idx + 3'd1;
                        r_gnt_valid <= 1'b0;
                        r_gnt       <= 8'h00;
                        r_timeout   <= w_expire;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt       = r_gnt;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4); observed word is
// {gnt_valid, gnt_idx, gnt, timeout}.
module tb_rr_arbiter8;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [12:0] obs;
    assign obs = {bus.gnt_valid, bus.gnt_idx, bus.gnt, bus.timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b1;
        tick();
        tick();
        e = {1'b0, 3'd0, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_hold: got %h need %h", obs, e); end
        rst = 1'b0; bus.req = 8'h00; bus.done = 1'b0;
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_release1: got %h need %h", obs, e); end
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_release2: got %h need %h", obs, e); end
    endtask

    task automatic test_rotation();
        logic [12:0] e;
        bus.req = 8'hFF; bus.done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            e = {1'b1, 3'(k % 8), 8'(1 << (k % 8)), 1'b0};
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rot_grant k=%0d: got %h need %h", k, obs, e); end
            tick();
            e = {1'b0, 3'(k % 8), 8'h00, 1'b0};
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rot_bubble k=%0d: got %h need %h", k, obs, e); end
        end
        bus.req = 8'h00; bus.done = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [12:0] e;
        bus.req = 8'h08;
        tick();
        e = {1'b1, 3'd3, 8'h08, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_grant: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        e = {1'b0, 3'd3, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_done: got %h need %h", obs, e); end
        bus.done = 1'b0;
        tick();
        e = {1'b1, 3'd3, 8'h08, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_regrant: got %h need %h", obs, e); end
        bus.req = 8'h00;
        tick();
        e = {1'b0, 3'd3, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_abandon: got %h need %h", obs, e); end
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL single_idle_hold: got %h need %h", obs, e); end
    endtask

    task automatic test_pointer_priority();
        logic [12:0] e;
        bus.req = 8'h20;
        tick();
        e = {1'b1, 3'd5, 8'h20, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL prio_grant5: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 8'h21;
        tick();
        e = {1'b1, 3'd0, 8'h01, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL prio_grant0_first: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        e = {1'b1, 3'd5, 8'h20, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL prio_grant5_next: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        logic [12:0] e;
        bus.req = 8'h04; bus.done = 1'b0;
        e = {1'b1, 3'd2, 8'h04, 1'b0};
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_hold c=%0d: got %h need %h", c, obs, e); end
            // Extra requests appearing mid-grant must not move the grant.
            bus.req = (c == 1) ? 8'h05 : 8'h04;
        end
        tick();
        e = {1'b0, 3'd2, 8'h00, 1'b1};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_pulse: got %h need %h", obs, e); end
        tick();
        e = {1'b1, 3'd2, 8'h04, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_regrant: got %h need %h", obs, e); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_hold2 c=%0d: got %h need %h", c, obs, e); end
        end
        bus.done = 1'b1;
        tick();
        e = {1'b0, 3'd2, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_done_wins: got %h need %h", obs, e); end
        bus.done = 1'b0; bus.req = 8'h00;
        tick();
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL tmo_pulse_once: got %h need %h", obs, e); end
    endtask

    task automatic test_abandon_reset();
        logic [12:0] e;
        bus.req = 8'h40;
        tick();
        e = {1'b1, 3'd6, 8'h40, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ab_grant6: got %h need %h", obs, e); end
        bus.req = 8'h00;
        tick();
        e = {1'b0, 3'd6, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ab_release: got %h need %h", obs, e); end
        bus.req = 8'hC1;
        tick();
        e = {1'b1, 3'd7, 8'h80, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ab_grant7: got %h need %h", obs, e); end
        rst = 1'b1;
        tick();
        e = {1'b0, 3'd0, 8'h00, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rst_midgrant: got %h need %h", obs, e); end
        rst = 1'b0;
        tick();
        e = {1'b1, 3'd0, 8'h01, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rst_ptr0: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        e = {1'b1, 3'd6, 8'h40, 1'b0};
        n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rst_next6: got %h need %h", obs, e); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 8'h00;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
        test_reset();
        test_rotation();
        test_single();
        test_pointer_priority();
        test_timeout();
        test_abandon_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
